// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types for the pipeline hazard controller.
//               - fwd_sel_e  : EX operand-forwarding mux select codes
//               - hz_state_e : hazard FSM states
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  // Operand source select for the EX-stage 3:1 muxes; 2'd3 is never produced.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN           = 2'd0,
    MISS          = 2'd1,
    MISS_REDIRECT = 2'd2
  } hz_state_e;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/forward_select.sv
`default_nettype none
// ============================================================================
// Module      : forward_select
// Description : Forwarding select for one EX-stage source operand.
//               MEM result has priority over WB result; x0 is never forwarded.
// Ports       : i_rs_ex  - EX source register index
//               i_rd_mem - MEM destination, i_we_mem - MEM writes rd
//               i_rd_wb  - WB destination,  i_we_wb  - WB writes rd
//               o_sel    - mux select (FWD_RF / FWD_WB / FWD_MEM)
// Revision    : 1.0 - initial release
// ============================================================================
module forward_select
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_rs_ex,
  input  logic [REG_ADDR_W-1:0] i_rd_mem,
  input  logic                  i_we_mem,
  input  logic [REG_ADDR_W-1:0] i_rd_wb,
  input  logic                  i_we_wb,
  output fwd_sel_e              o_sel
);

  logic w_hit_mem;
  logic w_hit_wb;

  assign w_hit_mem = i_we_mem && (i_rd_mem != '0) && (i_rd_mem == i_rs_ex);
  assign w_hit_wb  = i_we_wb  && (i_rd_wb  != '0) && (i_rd_wb  == i_rs_ex);

  always_comb begin
    o_sel = FWD_RF;
    if (w_hit_mem)     o_sel = FWD_MEM;
    else if (w_hit_wb) o_sel = FWD_WB;
  end

endmodule : forward_select
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Pipeline hazard controller for the 5-stage core.
//               Operand forwarding selects, load-use bubbles, mispredict
//               flushes, I/D-cache miss stalls with deferred redirect, and
//               stall/flush event counters.
// Ports       : clk_i, arst_ni         - clock, async active-low reset
//               rs*_addr_id/ex_i       - ID / EX source indices
//               rd_addr_ex_i,load_ex_i - EX destination, EX is a load
//               rd_addr_mem/wb_i, reg_we_mem/wb_i - MEM / WB writeback
//               mispredict_ex_i        - EX branch mispredicted
//               icache/dcache_stall_i  - cache miss in progress
//               forward_rs1/rs2_o      - EX operand mux selects
//               stall_*_o, flush_*_o   - per-stage hold / clear
//               stall_cnt_o, flush_cnt_o - event counters (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic [REG_ADDR_W-1:0] rs1_addr_id_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_id_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_ex_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_ex_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_ex_i,
  input  logic                  load_ex_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_mem_i,
  input  logic                  reg_we_mem_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_wb_i,
  input  logic                  reg_we_wb_i,
  input  logic                  mispredict_ex_i,
  input  logic                  icache_stall_i,
  input  logic                  dcache_stall_i,
  output logic [1:0]            forward_rs1_o,
  output logic [1:0]            forward_rs2_o,
  output logic                  stall_if_o,
  output logic                  stall_id_o,
  output logic                  stall_ex_o,
  output logic                  stall_mem_o,
  output logic                  stall_wb_o,
  output logic                  flush_id_o,
  output logic                  flush_ex_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

  fwd_sel_e              w_fwd_rs1;
  fwd_sel_e              w_fwd_rs2;
  hz_state_e             r_state;
  hz_state_e             w_state_nxt;
  logic                  w_cache_stall;
  logic                  w_load_use;
  logic [4:0]            w_stall;      // {if, id, ex, mem, wb}
  logic                  w_flush_id;
  logic                  w_flush_ex;
  logic                  w_mp_flush;   // flush caused by a mispredict (counted)
  logic [CNT_WIDTH-1:0]  r_stall_cnt;
  logic [CNT_WIDTH-1:0]  r_flush_cnt;

  // --------------------------------------------------------------------------
  // Forwarding
  // --------------------------------------------------------------------------
  forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .i_rs_ex  (rs1_addr_ex_i),
    .i_rd_mem (rd_addr_mem_i),
    .i_we_mem (reg_we_mem_i),
    .i_rd_wb  (rd_addr_wb_i),
    .i_we_wb  (reg_we_wb_i),
    .o_sel    (w_fwd_rs1)
  );

  forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .i_rs_ex  (rs2_addr_ex_i),
    .i_rd_mem (rd_addr_mem_i),
    .i_we_mem (reg_we_mem_i),
    .i_rd_wb  (rd_addr_wb_i),
    .i_we_wb  (reg_we_wb_i),
    .o_sel    (w_fwd_rs2)
  );

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  assign w_cache_stall = icache_stall_i | dcache_stall_i;
  assign w_load_use    = load_ex_i && (rd_addr_ex_i != '0) &&
                         ((rd_addr_ex_i == rs1_addr_id_i) ||
                          (rd_addr_ex_i == rs2_addr_id_i));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) r_state <= RUN;
    else          r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (w_cache_stall) w_state_nxt = mispredict_ex_i ? MISS_REDIRECT : MISS;
      end
      MISS: begin
        // On release the cycle behaves as RUN; a mispredict then flushes directly.
        if (!w_cache_stall)       w_state_nxt = RUN;
        else if (mispredict_ex_i) w_state_nxt = MISS_REDIRECT;
      end
      MISS_REDIRECT: begin
        if (!w_cache_stall) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: stall / flush decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_stall    = 5'b00000;
    w_flush_id = 1'b0;
    w_flush_ex = 1'b0;
    w_mp_flush = 1'b0;
    if (w_cache_stall) begin
      // Every state freezes the whole pipe while a miss is outstanding.
      w_stall = 5'b11111;
    end else if (r_state == MISS_REDIRECT) begin
      // Replay the latched redirect once; a still-high mispredict is the same event.
      w_flush_id = 1'b1;
      w_flush_ex = 1'b1;
      w_mp_flush = 1'b1;
    end else if (mispredict_ex_i) begin
      // ID is squashed, so any load-use against it is moot.
      w_flush_id = 1'b1;
      w_flush_ex = 1'b1;
      w_mp_flush = 1'b1;
    end else if (w_load_use) begin
      w_stall    = 5'b11000;
      w_flush_ex = 1'b1;
    end
  end

  // All outputs forced low while reset is asserted, regardless of inputs.
  assign forward_rs1_o = arst_ni ? w_fwd_rs1 : FWD_RF;
  assign forward_rs2_o = arst_ni ? w_fwd_rs2 : FWD_RF;
  assign stall_if_o    = arst_ni & w_stall[4];
  assign stall_id_o    = arst_ni & w_stall[3];
  assign stall_ex_o    = arst_ni & w_stall[2];
  assign stall_mem_o   = arst_ni & w_stall[1];
  assign stall_wb_o    = arst_ni & w_stall[0];
  assign flush_id_o    = arst_ni & w_flush_id;
  assign flush_ex_o    = arst_ni & w_flush_ex;

  // --------------------------------------------------------------------------
  // Event counters (wrap naturally)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (|w_stall)   r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      if (w_mp_flush) r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;

endmodule : hazard_unit
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Scoreboard bench for hazard_unit. A driver applies directed
//               vectors with hand-computed expected outputs and queues them;
//               a monitor pops and compares at each falling edge.
//               Counter width is reduced to 4 bits so wrap is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

  localparam int c_aw = 5;
  localparam int c_cw = 4;

  typedef struct packed {
    logic [1:0]      f1;
    logic [1:0]      f2;
    logic [4:0]      stall;   // {if, id, ex, mem, wb}
    logic [1:0]      flush;   // {id, ex}
    logic [c_cw-1:0] scnt;
    logic [c_cw-1:0] fcnt;
  } exp_t;

  logic            clk = 1'b0;
  logic            arst_n = 1'b0;
  logic [c_aw-1:0] rs1_id = '0, rs2_id = '0, rs1_ex = '0, rs2_ex = '0;
  logic [c_aw-1:0] rd_ex = '0, rd_mem = '0, rd_wb = '0;
  logic            load_ex = 1'b0, we_mem = 1'b0, we_wb = 1'b0;
  logic            mp = 1'b0, ic = 1'b0, dc = 1'b0;

  logic [1:0]      fwd1, fwd2;
  logic            s_if, s_id, s_ex, s_mem, s_wb, f_id, f_ex;
  logic [c_cw-1:0] scnt, fcnt;

  exp_t            q[$];
  logic [c_cw-1:0] e_scnt = '0;
  logic [c_cw-1:0] e_fcnt = '0;
  int              n_checks = 0;
  int              n_pass   = 0;

  hazard_unit #(.REG_ADDR_W(c_aw), .CNT_WIDTH(c_cw)) dut (
    .clk_i           (clk),
    .arst_ni         (arst_n),
    .rs1_addr_id_i   (rs1_id),
    .rs2_addr_id_i   (rs2_id),
    .rs1_addr_ex_i   (rs1_ex),
    .rs2_addr_ex_i   (rs2_ex),
    .rd_addr_ex_i    (rd_ex),
    .load_ex_i       (load_ex),
    .rd_addr_mem_i   (rd_mem),
    .reg_we_mem_i    (we_mem),
    .rd_addr_wb_i    (rd_wb),
    .reg_we_wb_i     (we_wb),
    .mispredict_ex_i (mp),
    .icache_stall_i  (ic),
    .dcache_stall_i  (dc),
    .forward_rs1_o   (fwd1),
    .forward_rs2_o   (fwd2),
    .stall_if_o      (s_if),
    .stall_id_o      (s_id),
    .stall_ex_o      (s_ex),
    .stall_mem_o     (s_mem),
    .stall_wb_o      (s_wb),
    .flush_id_o      (f_id),
    .flush_ex_o      (f_ex),
    .stall_cnt_o     (scnt),
    .flush_cnt_o     (fcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("fwd_rs1",   8'(fwd1), 8'(e.f1));
      chk("fwd_rs2",   8'(fwd2), 8'(e.f2));
      chk("stalls",    8'({s_if, s_id, s_ex, s_mem, s_wb}), 8'(e.stall));
      chk("flushes",   8'({f_id, f_ex}), 8'(e.flush));
      chk("stall_cnt", 8'(scnt), 8'(e.scnt));
      chk("flush_cnt", 8'(fcnt), 8'(e.fcnt));
    end
  end

  // Driver: one vector per cycle. mpf = this cycle's flush is a counted mispredict flush.
  task automatic vec(
    input logic rst_n_v,
    input logic [c_aw-1:0] r1id, r2id, r1ex, r2ex, rdex, input logic ld,
    input logic [c_aw-1:0] rdm, input logic wem,
    input logic [c_aw-1:0] rdw, input logic wew,
    input logic mpv, icv, dcv,
    input logic [1:0] ef1, ef2, input logic [4:0] est, input logic [1:0] efl,
    input logic mpf);
    exp_t e;
    @(posedge clk);
    #1;
    arst_n = rst_n_v;
    rs1_id = r1id; rs2_id = r2id; rs1_ex = r1ex; rs2_ex = r2ex;
    rd_ex = rdex; load_ex = ld; rd_mem = rdm; we_mem = wem;
    rd_wb = rdw; we_wb = wew; mp = mpv; ic = icv; dc = dcv;
    if (!rst_n_v) begin
      e_scnt = '0;
      e_fcnt = '0;
    end
    e = '{f1: ef1, f2: ef2, stall: est, flush: efl, scnt: e_scnt, fcnt: e_fcnt};
    q.push_back(e);
    if (rst_n_v) begin
      if (est != 5'b0) e_scnt = e_scnt + 1'b1;
      if (mpf)         e_fcnt = e_fcnt + 1'b1;
    end
  endtask

  // Shorthand for control-only vectors (no forwarding activity).
  task automatic ctl(input logic mpv, icv, dcv, input logic [4:0] est,
                     input logic [1:0] efl, input logic mpf);
    vec(1'b1, 0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0, mpv, icv, dcv,
        2'd0, 2'd0, est, efl, mpf);
  endtask

  initial begin
    //   rst  r1id r2id r1ex r2ex rdex ld  rdm wem rdw wew mp ic dc  f1 f2  stalls  flush mpf
    vec(0,   0,   0,   0,   0,   0,   0,  0,  0,  0,  0,  0, 0, 0,  0, 0, 5'b00000, 2'b00, 0);
    // Forwarding: MEM beats WB; x0 never forwarded; WB only; mixed sources
    vec(1,   0,   0,   5,   0,   0,   0,  5,  1,  5,  1,  0, 0, 0,  2, 0, 5'b00000, 2'b00, 0);
    vec(1,   0,   0,   0,   0,   0,   0,  0,  1,  0,  1,  0, 0, 0,  0, 0, 5'b00000, 2'b00, 0);
    vec(1,   0,   0,   6,   6,   0,   0,  6,  0,  6,  1,  0, 0, 0,  1, 1, 5'b00000, 2'b00, 0);
    vec(1,   0,   0,   4,   3,   0,   0,  3,  1,  4,  1,  0, 0, 0,  1, 2, 5'b00000, 2'b00, 0);
    // Load-use on rs2 -> one-cycle bubble, then clear
    vec(1,   0,   7,   0,   0,   7,   1,  0,  0,  0,  0,  0, 0, 0,  0, 0, 5'b11000, 2'b01, 0);
    vec(1,   0,   7,   0,   0,   0,   0,  0,  0,  0,  0,  0, 0, 0,  0, 0, 5'b00000, 2'b00, 0);
    // Load to x0 is not a hazard
    vec(1,   0,   0,   0,   0,   0,   1,  0,  0,  0,  0,  0, 0, 0,  0, 0, 5'b00000, 2'b00, 0);
    // Load-use plus mispredict -> flush wins, no stall
    vec(1,   7,   0,   0,   0,   7,   1,  0,  0,  0,  0,  1, 0, 0,  0, 0, 5'b00000, 2'b11, 1);
    // D-cache miss 4 cycles, mispredict pulse on cycle 2, flush on release
    ctl(0, 0, 1, 5'b11111, 2'b00, 0);
    ctl(1, 0, 1, 5'b11111, 2'b00, 0);
    ctl(0, 0, 1, 5'b11111, 2'b00, 0);
    ctl(0, 0, 1, 5'b11111, 2'b00, 0);
    ctl(0, 0, 0, 5'b00000, 2'b11, 1);
    ctl(0, 0, 0, 5'b00000, 2'b00, 0);
    // Mispredict held high through a miss -> single flush on release
    ctl(1, 0, 1, 5'b11111, 2'b00, 0);
    ctl(1, 0, 1, 5'b11111, 2'b00, 0);
    ctl(1, 0, 0, 5'b00000, 2'b11, 1);
    ctl(0, 0, 0, 5'b00000, 2'b00, 0);
    // I-cache miss with same-cycle mispredict, then reset mid-MISS_REDIRECT
    ctl(1, 1, 0, 5'b11111, 2'b00, 0);
    ctl(0, 1, 0, 5'b11111, 2'b00, 0);
    vec(0,   0,   0,   5,   0,   0,   0,  5,  1,  0,  0,  0, 0, 1,  0, 0, 5'b00000, 2'b00, 0);
    ctl(0, 0, 0, 5'b00000, 2'b00, 0);
    // Miss release cycle is evaluated as RUN: load-use applies immediately
    ctl(0, 0, 1, 5'b11111, 2'b00, 0);
    vec(1,   9,   0,   0,   0,   9,   1,  0,  0,  0,  0,  0, 0, 0,  0, 0, 5'b11000, 2'b01, 0);
    ctl(0, 0, 0, 5'b00000, 2'b00, 0);
    // Long I-cache stall: stall_cnt reaches 15 and wraps to 0
    for (int i = 0; i < 16; i++) ctl(0, 1, 0, 5'b11111, 2'b00, 0);
    ctl(0, 0, 0, 5'b00000, 2'b00, 0);
    ctl(0, 0, 0, 5'b00000, 2'b00, 0);
    @(posedge clk);
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_hazard_unit
`default_nettype wire
